frame_peak_buffer: RTL and testbench

Upstream stage of the data normalisation block. It buffers one fixed-length frame of samples and tracks the frame peak. It then derives the per-frame normalisation factor from that peak and replays the frame, presenting each sample together with the factor. Its outputs feed the normaliser's data and factor inputs directly.

---
 rtl/frame_peak_buffer_pkg.sv | 29 ++
 rtl/frame_buf_ram.sv | 35 +++
 rtl/frame_peak_buffer.sv | 183 ++++++++++++++++++
 tb/tb_frame_peak_buffer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_peak_buffer_pkg.sv
// Shared definitions for the frame peak buffer and the normaliser it feeds.
// Holds the controller state encoding, the default sample/factor widths
// (so both blocks agree on their interface) and a constant clog2 helper
// used to size the frame pointers.
package frame_peak_buffer_pkg;

  // Widths shared with the normaliser's data and factor inputs.
  localparam int DEFAULT_DIN_WIDTH    = 11;
  localparam int DEFAULT_FACTOR_WIDTH = 11;

  // Controller states: FILL collects a frame, CALC derives the factor,
  // DRAIN replays the buffered frame.
  typedef enum logic [1:0] {
    FILL  = 2'd0,
    CALC  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Ceiling log2, never smaller than 1 so a pointer always has a bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/frame_buf_ram.sv
// Frame storage: DEPTH x WIDTH register array.
// Ports:
//   clk    - clock, write on rising edge
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address (combinational read)
//   rdata  - read data
// Contents are not reset; the controller only reads entries it has written.
module frame_buf_ram #(
  parameter int DEPTH  = 64,
  parameter int WIDTH  = 11,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Asynchronous read lets the output register load mem[rd_ptr] in the
  // same cycle the pointer is presented.
  assign rdata = mem_q[raddr];

endmodule

// File: rtl/frame_peak_buffer.sv
// Frame peak buffer: collects one FRAME_LEN-sample frame while tracking its
// peak, derives the normalisation factor (peak >> PEAK_SHIFT, clamped to at
// least 1 and saturated to FACTOR_WIDTH bits), then replays the frame with
// the factor alongside each sample.
// Ports:
//   clk, rst     - clock and synchronous active-high reset
//   in_valid     - upstream sample valid
//   this_ready   - block accepts a sample (high only while filling)
//   in_data      - input sample
//   out_valid    - output sample valid
//   next_ready   - downstream accepts
//   out_data     - replayed sample
//   norm_factor  - factor for the frame currently leaving
//   out_last     - final sample of a frame
module frame_peak_buffer
  import frame_peak_buffer_pkg::*;
#(
  parameter int DIN_WIDTH    = DEFAULT_DIN_WIDTH,
  parameter int FACTOR_WIDTH = DEFAULT_FACTOR_WIDTH,
  parameter int FRAME_LEN    = 64,
  parameter int PEAK_SHIFT   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    this_ready,
  input  logic [DIN_WIDTH-1:0]    in_data,
  output logic                    out_valid,
  input  logic                    next_ready,
  output logic [DIN_WIDTH-1:0]    out_data,
  output logic [FACTOR_WIDTH-1:0] norm_factor,
  output logic                    out_last
);

  localparam int PTR_W = clog2(FRAME_LEN);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FRAME_LEN - 1);
  // Common width for comparing the shifted peak with the factor ceiling.
  localparam int CMP_W = (DIN_WIDTH > FACTOR_WIDTH) ? DIN_WIDTH : FACTOR_WIDTH;

  state_e                  state_q, state_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [DIN_WIDTH-1:0]    peak_q, peak_d;
  logic                    out_valid_q, out_valid_d;
  logic [DIN_WIDTH-1:0]    out_data_q, out_data_d;
  logic                    out_last_q, out_last_d;
  logic [FACTOR_WIDTH-1:0] norm_factor_q, norm_factor_d;

  logic                    mem_we;
  logic [DIN_WIDTH-1:0]    mem_rdata;
  logic                    out_free;
  logic [DIN_WIDTH-1:0]    peak_shifted;
  logic [CMP_W-1:0]        shifted_ext;
  logic [CMP_W-1:0]        factor_max_ext;
  logic [FACTOR_WIDTH-1:0] factor_calc;

  frame_buf_ram #(
    .DEPTH  (FRAME_LEN),
    .WIDTH  (DIN_WIDTH),
    .ADDR_W (PTR_W)
  ) u_ram (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr_q),
    .wdata (in_data),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

  // Factor from the completed frame's peak. A zero result is clamped to 1 so
  // the normaliser never divides by zero; oversize values saturate.
  always_comb begin
    peak_shifted   = peak_q >> PEAK_SHIFT;
    shifted_ext    = CMP_W'(peak_shifted);
    factor_max_ext = CMP_W'({FACTOR_WIDTH{1'b1}});
    factor_calc    = FACTOR_WIDTH'(shifted_ext);
    if (shifted_ext == '0) begin
      factor_calc = FACTOR_WIDTH'(1);
    end else if (shifted_ext > factor_max_ext) begin
      factor_calc = '1;
    end
  end

  // The output register may take a new value when empty or being consumed.
  assign out_free = !out_valid_q || next_ready;

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    peak_d        = peak_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_last_d    = out_last_q;
    norm_factor_d = norm_factor_q;
    mem_we        = 1'b0;

    case (state_q)
      FILL: begin
        // A held last sample of the previous frame drains while filling.
        if (next_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end
        if (in_valid) begin
          mem_we = 1'b1;
          if (in_data > peak_q) begin
            peak_d = in_data;
          end
          if (wr_ptr_q == LAST_PTR) begin
            wr_ptr_d = '0;
            state_d  = CALC;
          end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
        end
      end

      CALC: begin
        if (next_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end
        // Factor switches only once the previous frame's last sample has
        // left, so that sample always carries its own frame's factor.
        if (out_free) begin
          norm_factor_d = factor_calc;
          rd_ptr_d      = '0;
          state_d       = DRAIN;
        end
      end

      DRAIN: begin
        if (out_free) begin
          out_data_d  = mem_rdata;
          out_last_d  = (rd_ptr_q == LAST_PTR);
          out_valid_d = 1'b1;
          if (rd_ptr_q == LAST_PTR) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            peak_d   = '0;
            state_d  = FILL;
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = FILL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FILL;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      peak_q        <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_last_q    <= 1'b0;
      norm_factor_q <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      peak_q        <= peak_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_last_q    <= out_last_d;
      norm_factor_q <= norm_factor_d;
    end
  end

  assign this_ready  = (state_q == FILL);
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_last    = out_last_q;
  assign norm_factor = norm_factor_q;

endmodule

// File: tb/tb_frame_peak_buffer.sv
// Directed bench for frame_peak_buffer: ramp, all-zero, random backpressure,
// factor saturation (second instance with 6-bit factor), frame overlap with
// a held last sample, and reset in the middle of a replay.
module tb_frame_peak_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        next_ready = 1'b1;
  logic [10:0] in_data = '0;

  logic        this_ready, out_valid, out_last;
  logic [10:0] out_data, norm_factor;

  logic        this_ready6, out_valid6, out_last6;
  logic [10:0] out_data6;
  logic [5:0]  norm_factor6;

  int check_count = 0;
  int error_count = 0;
  int ready_mode  = 0;

  logic [10:0] stim [64];
  int got_data[$], got_last[$], got_fac[$];
  int exp_data[$], exp_last[$], exp_fac[$];

  frame_peak_buffer #(
    .DIN_WIDTH(11), .FACTOR_WIDTH(11), .FRAME_LEN(64), .PEAK_SHIFT(2)
  ) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .this_ready(this_ready),
    .in_data(in_data), .out_valid(out_valid), .next_ready(next_ready),
    .out_data(out_data), .norm_factor(norm_factor), .out_last(out_last)
  );

  frame_peak_buffer #(
    .DIN_WIDTH(11), .FACTOR_WIDTH(6), .FRAME_LEN(64), .PEAK_SHIFT(2)
  ) u_dut6 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .this_ready(this_ready6),
    .in_data(in_data), .out_valid(out_valid6), .next_ready(next_ready),
    .out_data(out_data6), .norm_factor(norm_factor6), .out_last(out_last6)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check, reports mismatches.
  task automatic checkOutput(input string tag, input int actual, input int expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Reference factor: peak >> 2, clamped to 1, saturated to fw bits.
  function automatic int expFactor(input int peak, input int fw);
    int s;
    s = peak >> 2;
    if (s == 0) return 1;
    if (s > (1 << fw) - 1) return (1 << fw) - 1;
    return s;
  endfunction

  // Downstream ready pattern, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       next_ready = 1'b1;
      1:       next_ready = 1'($urandom_range(0, 1));
      2:       next_ready = !(out_valid && out_last);
      default: next_ready = 1'b0;
    endcase
  end

  // Record every transfer and check output stability under backpressure.
  logic        prev_stall = 1'b0;
  logic        prev_rst = 1'b1;
  logic [10:0] prev_data = '0;
  logic [10:0] prev_fac = '0;
  logic        prev_last = 1'b0;

  always @(negedge clk) begin
    if (!rst && out_valid && next_ready) begin
      got_data.push_back(int'(out_data));
      got_last.push_back(int'(out_last));
      got_fac.push_back(int'(norm_factor));
    end
    if (prev_stall && !prev_rst && !rst) begin
      checkOutput("hold_data", int'(out_data), int'(prev_data));
      checkOutput("hold_last", int'(out_last), int'(prev_last));
      checkOutput("hold_factor", int'(norm_factor), int'(prev_fac));
    end
    prev_stall = out_valid && !next_ready;
    prev_rst   = rst;
    prev_data  = out_data;
    prev_last  = out_last;
    prev_fac   = norm_factor;
  end

  // Push stim[0..63] honouring this_ready; queue the expected replay.
  task automatic applyStimulus();
    int idx;
    int budget;
    int peak;
    int fac;
    logic acc;
    peak = 0;
    for (int i = 0; i < 64; i++) begin
      if (int'(stim[i]) > peak) peak = int'(stim[i]);
    end
    fac = expFactor(peak, 11);
    for (int i = 0; i < 64; i++) begin
      exp_data.push_back(int'(stim[i]));
      exp_last.push_back((i == 63) ? 1 : 0);
      exp_fac.push_back(fac);
    end
    idx = 0;
    budget = 0;
    while (idx < 64 && budget < 5000) begin
      in_valid = 1'b1;
      in_data  = stim[idx];
      @(negedge clk);
      acc = this_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
      budget++;
    end
    in_valid = 1'b0;
    if (idx < 64) checkOutput("push_timeout", idx, 64);
  endtask

  task automatic waitOutputs();
    int b;
    b = 0;
    while (got_data.size() < exp_data.size() && b < 3000) begin
      @(posedge clk);
      #1;
      b++;
    end
    if (b >= 3000) checkOutput("wait_timeout", got_data.size(), exp_data.size());
  endtask

  task automatic compareAll();
    checkOutput("out_count", got_data.size(), exp_data.size());
    for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
      checkOutput($sformatf("data[%0d]", i), got_data[i], exp_data[i]);
      checkOutput($sformatf("last[%0d]", i), got_last[i], exp_last[i]);
      checkOutput($sformatf("factor[%0d]", i), got_fac[i], exp_fac[i]);
    end
    got_data.delete(); got_last.delete(); got_fac.delete();
    exp_data.delete(); exp_last.delete(); exp_fac.delete();
  endtask

  initial begin
    int b;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_out_data", int'(out_data), 0);
    checkOutput("rst_out_last", int'(out_last), 0);
    checkOutput("rst_factor", int'(norm_factor), 0);
    checkOutput("rst_ready", int'(this_ready), 1);
    @(posedge clk);
    #1;

    // Ramp 16*i, downstream always ready: peak 1008 -> factor 252
    $display("[TB] ramp frame");
    ready_mode = 0;
    for (int i = 0; i < 64; i++) stim[i] = 11'(16 * i);
    applyStimulus();
    @(negedge clk);
    checkOutput("lat_calc_valid", int'(out_valid), 0);
    checkOutput("calc_ready", int'(this_ready), 0);
    @(negedge clk);
    checkOutput("lat_drain_valid", int'(out_valid), 0);
    @(negedge clk);
    checkOutput("lat_first_valid", int'(out_valid), 1);
    checkOutput("first_data", int'(out_data), 0);
    checkOutput("first_factor", int'(norm_factor), 252);
    b = 0;
    while (!(out_valid && out_last) && b < 200) begin
      checkOutput("drain_ready", int'(this_ready), 0);
      @(negedge clk);
      b++;
    end
    checkOutput("ramp_last_seen", int'(out_last), 1);
    checkOutput("refill_ready", int'(this_ready), 1);
    @(posedge clk);
    #1;
    waitOutputs();
    compareAll();

    // All-zero frame: factor clamps to 1
    $display("[TB] zero frame");
    for (int i = 0; i < 64; i++) stim[i] = '0;
    applyStimulus();
    waitOutputs();
    compareAll();
    checkOutput("zero_factor", int'(norm_factor), 1);

    // Random frame under random backpressure
    $display("[TB] random backpressure");
    ready_mode = 1;
    for (int i = 0; i < 64; i++) stim[i] = 11'($urandom_range(0, 2047));
    applyStimulus();
    waitOutputs();
    compareAll();
    ready_mode = 0;

    // Saturation: 2047 peak -> 511 on 11-bit factor, 63 on 6-bit factor
    $display("[TB] factor saturation");
    for (int i = 0; i < 64; i++) stim[i] = 11'($urandom_range(0, 1000));
    stim[20] = 11'd2047;
    applyStimulus();
    b = 0;
    do begin
      @(negedge clk);
      b++;
    end while (!out_valid && b < 20);
    checkOutput("sat_factor11", int'(norm_factor), 511);
    checkOutput("sat_factor6", int'(norm_factor6), 63);
    checkOutput("sat6_valid", int'(out_valid6), 1);
    checkOutput("sat6_data", int'(out_data6), int'(stim[0]));
    checkOutput("sat6_last", int'(out_last6), 0);
    checkOutput("sat6_ready", int'(this_ready6), 0);
    @(posedge clk);
    #1;
    waitOutputs();
    compareAll();

    // Overlap: hold A's last sample (factor 252) while frame B (peak 400) fills
    $display("[TB] overlap with held last sample");
    ready_mode = 2;
    for (int i = 0; i < 64; i++) stim[i] = 11'(16 * i);
    applyStimulus();
    b = 0;
    do begin
      @(negedge clk);
      b++;
    end while (!(out_valid && out_last) && b < 300);
    @(posedge clk);
    #1;
    for (int i = 0; i < 64; i++) stim[i] = 11'(i);
    stim[10] = 11'd400;
    applyStimulus();
    @(negedge clk);
    checkOutput("ovl_valid", int'(out_valid), 1);
    checkOutput("ovl_last", int'(out_last), 1);
    checkOutput("ovl_data", int'(out_data), 1008);
    checkOutput("ovl_factor", int'(norm_factor), 252);
    checkOutput("ovl_ready", int'(this_ready), 0);
    repeat (3) @(negedge clk);
    checkOutput("ovl_factor_late", int'(norm_factor), 252);
    @(posedge clk);
    #1;
    ready_mode = 0;
    waitOutputs();
    compareAll();
    checkOutput("ovl_factor_b", int'(norm_factor), 100);

    // Reset after 10 replayed samples, then a fresh frame
    $display("[TB] reset mid-drain");
    for (int i = 0; i < 64; i++) stim[i] = 11'($urandom_range(0, 2047));
    applyStimulus();
    b = 0;
    while (got_data.size() < 10 && b < 200) begin
      @(posedge clk);
      #1;
      b++;
    end
    checkOutput("pre_rst_outputs", int'(got_data.size() >= 10), 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_valid", int'(out_valid), 0);
    checkOutput("mid_rst_factor", int'(norm_factor), 0);
    checkOutput("mid_rst_ready", int'(this_ready), 1);
    checkOutput("mid_rst_last", int'(out_last), 0);
    got_data.delete(); got_last.delete(); got_fac.delete();
    exp_data.delete(); exp_last.delete(); exp_fac.delete();
    @(posedge clk);
    #1;
    for (int i = 0; i < 64; i++) stim[i] = 11'($urandom_range(0, 2047));
    applyStimulus();
    waitOutputs();
    compareAll();

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
